// File: rtl/systolic_pkg.sv
// Shared defaults and drain state encoding
// for the systolic array and its collectors.
`timescale 1ns/1ps
package systolic_pkg;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_ACC_WIDTH  = DEF_DATA_WIDTH * DEF_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COLLECT,
    ST_FLUSH
  } drain_state_t;

endpackage

// File: rtl/systolic_row_fifo.sv
// Synchronous row FIFO with a registered head word
// that reads zero whenever the FIFO is empty.
`timescale 1ns/1ps
module systolic_row_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_nx;
  logic [AW:0]      rd_nx;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_nx   = wr_ptr + (AW+1)'(do_push);
  assign rd_nx   = rd_ptr + (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // A push landing in the slot about to become head bypasses the memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_nx;
      rd_ptr <= rd_nx;
      if (wr_nx == rd_nx)
        head <= '0;
      else if (do_push && rd_nx[AW-1:0] == wr_ptr[AW-1:0])
        head <= push_data;
      else
        head <= mem[rd_nx[AW-1:0]];
    end
  end

endmodule

// File: rtl/systolic_drain.sv
// De-skews the array's diagonal result wavefront
// and queues aligned rows behind a valid/ready port.
`timescale 1ns/1ps
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE    = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH     = DATA_WIDTH * DATA_WIDTH,
  parameter int PIPE_LAT      = 1,
  parameter int FIFO_DEPTH    = 4,
  parameter int ROW_CNT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ROW_CNT_WIDTH-1:0]       num_rows,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] output_row,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int BUS   = ARRAY_SIZE * ACC_WIDTH;
  localparam int FIRST = PIPE_LAT + ARRAY_SIZE - 2;
  localparam int CNT_W = $clog2(PIPE_LAT + ARRAY_SIZE + 1);

  drain_state_t             state;
  logic [ROW_CNT_WIDTH-1:0] num_q;
  logic [ROW_CNT_WIDTH-1:0] rows;
  logic [CNT_W-1:0]         cnt;
  logic [BUS-1:0]           aligned;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic                     last_row;

  // Lane j is delayed so every lane lines up with the last one.
  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
    localparam int D = ARRAY_SIZE - 1 - j;
    if (D == 0) begin : g_direct
      assign aligned[j*ACC_WIDTH +: ACC_WIDTH] =
        output_row[j*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      logic [ACC_WIDTH-1:0] pipe [D];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < D; s++) pipe[s] <= '0;
        end else begin
          pipe[0] <= output_row[j*ACC_WIDTH +: ACC_WIDTH];
          for (int s = 1; s < D; s++) pipe[s] <= pipe[s-1];
        end
      end
      assign aligned[j*ACC_WIDTH +: ACC_WIDTH] = pipe[D-1];
    end
  end

  assign push = (state == ST_WAIT && cnt == CNT_W'(FIRST)) ||
                (state == ST_COLLECT);
  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;
  assign busy      = (state != ST_IDLE);
  assign last_row  = (rows == num_q - 1'b1);

  systolic_row_fifo #(
    .WIDTH (BUS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (aligned),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (out_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      num_q    <= '0;
      rows     <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push && full && !pop) overflow <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (start && num_rows != '0) begin
            num_q    <= num_rows;
            rows     <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (push) begin
            rows  <= rows + 1'b1;
            state <= last_row ? ST_FLUSH : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          rows <= rows + 1'b1;
          if (last_row) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (empty) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Output-side collector for the `systolic` array. The array emits results as a diagonal wavefront: column j of activation row k appears on its output lane j cycles after column 0. `systolic_drain` samples the array's `output_row` bus, de-skews the columns, and buffers complete result rows in a FIFO. It presents each row to downstream logic through a valid/ready handshake. It sits between the array and whatever consumes results, and mirrors the skewed activation feed on the array's input side.

## Interface
- `ARRAY_SIZE`, 4: number of columns/lanes.
- `DATA_WIDTH`, 4: operand width of the array.
- `ACC_WIDTH`, `DATA_WIDTH*DATA_WIDTH`: per-lane result width, matching the array's output lanes.
- `PIPE_LAT`, 1: rising edges from `start` to column 0 of row 0 being valid on `output_row`.
- `FIFO_DEPTH`, 4: buffered aligned rows; must be a power of two and at least 2.
- `ROW_CNT_WIDTH`, 8: width of `num_rows`.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `start` in 1: one-cycle pulse marking the first skewed activation entering the array.
- `num_rows` in `ROW_CNT_WIDTH`: rows to collect; sampled on the accepted `start`.
- `output_row` in `ARRAY_SIZE*ACC_WIDTH`: array results; lane j is `[j*ACC_WIDTH +: ACC_WIDTH]`.
- `out_data` out `ARRAY_SIZE*ACC_WIDTH`: aligned row, same lane packing as `output_row`.
- `out_valid` out 1: `out_data` holds a row.
- `out_ready` in 1: downstream accepts the row.
- `busy` out 1: a collection is in progress (state is not IDLE).
- `done` out 1: one-cycle pulse when a collection completes.
- `overflow` out 1: sticky; at least one row was dropped.

## Operation
- States: IDLE, WAIT, COLLECT, FLUSH.
- IDLE → WAIT: on `start`=1 with `num_rows`≠0. Latch `num_rows`, clear `overflow`, clear the cycle counter.
- A `start` pulse is ignored while `busy`=1. A `start` with `num_rows`=0 is ignored.
- Sampling rule: call the accepting edge S. Column j of row k is the value of lane j sampled at edge S+PIPE_LAT+k+j.
- De-skew: lane j passes through ARRAY_SIZE−1−j register stages. Lane ARRAY_SIZE−1 is used directly.
- WAIT → COLLECT: when the row-0 aligned write edge is reached.
- COLLECT: one aligned row is written per cycle, with row k written at edge S+PIPE_LAT+ARRAY_SIZE−1+k. After `num_rows` writes, go to FLUSH.
- FLUSH → IDLE: when the FIFO is empty. `done` pulses in the cycle after the transition edge.
- Full FIFO handling: the array cannot be stalled. A write into a full FIFO with no pop on the same edge drops that row and sets `overflow`. A write with a simultaneous pop on a full FIFO succeeds.
- `overflow` stays set until the next accepted `start`.
- Handshake: a pop occurs on an edge where `out_valid`=1 and `out_ready`=1. `out_data` is stable while `out_valid`=1 and `out_ready`=0. `out_data` is 0 whenever `out_valid`=0.
- Row count and pointers wrap modulo their widths. Occupancy is tracked with an extra pointer bit so full and empty are distinguishable.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `overflow`=0, FIFO empty, state IDLE.
- `busy`=1 from the cycle after edge S until the FLUSH→IDLE edge.
- Latency: `out_valid` first rises in the cycle after edge S+PIPE_LAT+ARRAY_SIZE−1. With default parameters this is after edge S+4.
- Throughput: one row per cycle when `out_ready`=1 continuously.
- Reset asserted mid-operation drops all buffered rows, returns to IDLE, and drives all outputs to their reset values asynchronously.

## Structure
- Shared package `systolic_pkg`: defaults for `ARRAY_SIZE`, `DATA_WIDTH`, `ACC_WIDTH`; drain state enumeration.
- One sub-module, `systolic_row_fifo`: synchronous FIFO with push, pop, full, empty, and registered head.
- De-skew registers, the counter, and the FSM live in `systolic_drain`.

## Test plan
Defaults throughout: ARRAY_SIZE=4, PIPE_LAT=1, FIFO_DEPTH=4, ACC_WIDTH=16.
- Reset: hold `reset`=0 with random inputs → all outputs 0; no `out_valid` after release without `start`.
- Single row: `start`, `num_rows`=1; lane j = 0x0010+j at edge S+1+j, 0xFFFF at all other edges → exactly one beat, lanes 3..0 = 0x13, 0x12, 0x11, 0x10. `out_valid` first high after S+4; `done` one cycle after the pop.
- Streaming: `num_rows`=4, `out_ready`=1; lane j at edge S+1+k+j = 16k+j → four consecutive beats, rows 0..3 in order; `done` once; `overflow`=0.
- Backpressure: `num_rows`=6, `out_ready`=0 until after edge S+9 → rows 4 and 5 dropped, `overflow`=1. Then 4 beats (rows 0..3) and `done`. Next `start` clears `overflow`.
- Ignored starts: `start` during COLLECT, or `num_rows`=0 in IDLE → no state change, no extra beats, no extra `done`.
- Mid-run reset: assert `reset`=0 during COLLECT with 2 rows buffered → outputs 0 immediately. A fresh single-row run afterwards matches the single-row expectations.
